// File: rtl/instr_aligner.sv
// rtl/instr_aligner.sv - RV32IC fetch parcel aligner
// Splits word-aligned fetch words into 16/32-bit instructions, including word-straddling ones.
module instr_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_data,
   input  logic [31:0] mem_addr,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic        instr_compressed,
   output logic [31:0] instr_pc
);

   logic [47:0] slots_q, slots_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] head_pc_q, head_pc_d;
   logic        drop_low_q, drop_low_d;
   logic [31:0] exp_addr_q, exp_addr_d;
   logic        synced_q, synced_d;

   logic        head_comp;
   logic        fire;
   logic [1:0]  consumed;
   logic [1:0]  remain;
   logic [47:0] shifted;
   logic        hit;

   always_comb begin
      head_comp = slots_q[1:0] != 2'b11;
      instr_valid = ((cnt_q != 2'd0) && head_comp) || (cnt_q >= 2'd2);
      instr_compressed = (cnt_q != 2'd0) && head_comp;
      instr_data = head_comp ? {16'h0000, slots_q[15:0]} : slots_q[31:0];
      instr_pc = head_pc_q;

      fire = instr_valid && instr_ready;
      consumed = fire ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
      remain = cnt_q - consumed;
      case (consumed)
         2'd1:    shifted = {16'h0000, slots_q[47:16]};
         2'd2:    shifted = {32'h0000_0000, slots_q[47:32]};
         default: shifted = slots_q;
      endcase

      // Combinational from instr_ready: a compressed fire frees the slot a new word needs.
      mem_ready = !flush && (remain <= 2'd1);
      hit = mem_valid && mem_ready && (mem_addr == exp_addr_q);

      slots_d = shifted;
      cnt_d = remain;
      head_pc_d = head_pc_q + (fire ? (head_comp ? 32'd2 : 32'd4) : 32'd0);
      drop_low_d = drop_low_q;
      exp_addr_d = exp_addr_q;
      synced_d = synced_q;

      if (hit) begin
         if (drop_low_q) begin
            if (remain == 2'd0) slots_d[15:0] = mem_data[31:16];
            else                slots_d[31:16] = mem_data[31:16];
            cnt_d = remain + 2'd1;
         end else begin
            if (remain == 2'd0) slots_d[31:0] = mem_data;
            else                slots_d[47:16] = mem_data;
            cnt_d = remain + 2'd2;
         end
         drop_low_d = 1'b0;
         exp_addr_d = exp_addr_q + 32'd4;
         synced_d = 1'b1;
      end

      if (flush) begin
         slots_d = 48'h0;
         cnt_d = 2'd0;
         head_pc_d = flush_pc;
         exp_addr_d = {flush_pc[31:2], 2'b00};
         drop_low_d = flush_pc[1];
         synced_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slots_q <= 48'h0;
         cnt_q <= 2'd0;
         head_pc_q <= RESET_PC;
         drop_low_q <= 1'b0;
         exp_addr_q <= RESET_PC;
         synced_q <= 1'b0;
      end else begin
         slots_q <= slots_d;
         cnt_q <= cnt_d;
         head_pc_q <= head_pc_d;
         drop_low_q <= drop_low_d;
         exp_addr_q <= exp_addr_d;
         synced_q <= synced_d;
      end
   end

endmodule

// File: tb/tb_instr_aligner.sv
// tb/tb_instr_aligner.sv - directed self-checking bench for instr_aligner
module tb_instr_aligner;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_data;
   logic [31:0] mem_addr;
   logic        flush;
   logic [31:0] flush_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic        instr_compressed;
   logic [31:0] instr_pc;

   int errors = 0;
   int checks = 0;

   instr_aligner #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data), .mem_addr(mem_addr),
      .flush(flush), .flush_pc(flush_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
      .instr_compressed(instr_compressed), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      mem_valid = 1'b0; mem_data = 32'h0; mem_addr = 32'h0;
      flush = 1'b0; flush_pc = 32'h0; instr_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      settle();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
      checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", instr_data); end
      checks++; if (instr_compressed !== 1'b0) begin errors++; $display("FAIL reset_comp: got %0b want 0", instr_compressed); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", instr_pc); end
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %0b want 1", mem_ready); end
   endtask

   task automatic test_aligned();
      do_reset();
      instr_ready = 1'b1;
      mem_valid = 1'b1; mem_data = 32'h00A00093; mem_addr = 32'h0;
      settle();
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL al_ready0: got %0b want 1", mem_ready); end
      tick();
      mem_data = 32'h00100113; mem_addr = 32'h4;
      settle();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL al_valid0: got %0b want 1", instr_valid); end
      checks++; if (instr_data !== 32'h00A00093) begin errors++; $display("FAIL al_data0: got %h want 00a00093", instr_data); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL al_pc0: got %h want 00000000", instr_pc); end
      checks++; if (instr_compressed !== 1'b0) begin errors++; $display("FAIL al_comp0: got %0b want 0", instr_compressed); end
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL al_ready1: got %0b want 1", mem_ready); end
      tick();
      mem_valid = 1'b0;
      settle();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL al_valid1: got %0b want 1", instr_valid); end
      checks++; if (instr_data !== 32'h00100113) begin errors++; $display("FAIL al_data1: got %h want 00100113", instr_data); end
      checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL al_pc1: got %h want 00000004", instr_pc); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL al_drain: got %0b want 0", instr_valid); end
      checks++; if (instr_pc !== 32'h8) begin errors++; $display("FAIL al_pc2: got %h want 00000008", instr_pc); end
   endtask

   task automatic test_compressed_pair();
      do_reset();
      instr_ready = 1'b1;
      mem_valid = 1'b1; mem_data = 32'h45054501; mem_addr = 32'h0;
      tick();
      mem_valid = 1'b0;
      settle();
      checks++; if (instr_data !== 32'h00004501) begin errors++; $display("FAIL cp_data0: got %h want 00004501", instr_data); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL cp_pc0: got %h want 00000000", instr_pc); end
      checks++; if (instr_compressed !== 1'b1) begin errors++; $display("FAIL cp_comp0: got %0b want 1", instr_compressed); end
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL cp_ready: got %0b want 1", mem_ready); end
      tick();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL cp_valid1: got %0b want 1", instr_valid); end
      checks++; if (instr_data !== 32'h00004505) begin errors++; $display("FAIL cp_data1: got %h want 00004505", instr_data); end
      checks++; if (instr_pc !== 32'h2) begin errors++; $display("FAIL cp_pc1: got %h want 00000002", instr_pc); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL cp_drain: got %0b want 0", instr_valid); end
   endtask

   task automatic test_straddle();
      do_reset();
      instr_ready = 1'b1;
      mem_valid = 1'b1; mem_data = 32'h00934501; mem_addr = 32'h0;
      tick();
      mem_valid = 1'b0;
      settle();
      checks++; if (instr_data !== 32'h00004501) begin errors++; $display("FAIL st_data0: got %h want 00004501", instr_data); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL st_gap: got %0b want 0", instr_valid); end
      mem_valid = 1'b1; mem_data = 32'h123400A0; mem_addr = 32'h4;
      settle();
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL st_ready: got %0b want 1", mem_ready); end
      tick();
      mem_valid = 1'b0;
      settle();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL st_valid: got %0b want 1", instr_valid); end
      checks++; if (instr_data !== 32'h00A00093) begin errors++; $display("FAIL st_data1: got %h want 00a00093", instr_data); end
      checks++; if (instr_pc !== 32'h2) begin errors++; $display("FAIL st_pc1: got %h want 00000002", instr_pc); end
      checks++; if (instr_compressed !== 1'b0) begin errors++; $display("FAIL st_comp1: got %0b want 0", instr_compressed); end
      tick();
      checks++; if (instr_data !== 32'h00001234) begin errors++; $display("FAIL st_data2: got %h want 00001234", instr_data); end
      checks++; if (instr_pc !== 32'h6) begin errors++; $display("FAIL st_pc2: got %h want 00000006", instr_pc); end
   endtask

   task automatic test_flush_stale();
      do_reset();
      flush = 1'b1; flush_pc = 32'h102;
      mem_valid = 1'b1; mem_data = 32'h11111111; mem_addr = 32'h0;
      settle();
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL fl_ready_in_flush: got %0b want 0", mem_ready); end
      tick();
      flush = 1'b0;
      mem_data = 32'hDEADBEEF; mem_addr = 32'h200;
      settle();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_valid0: got %0b want 0", instr_valid); end
      checks++; if (instr_pc !== 32'h102) begin errors++; $display("FAIL fl_pc0: got %h want 00000102", instr_pc); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_stale: got %0b want 0", instr_valid); end
      mem_data = 32'h4505CAFE; mem_addr = 32'h100;
      tick();
      mem_valid = 1'b0;
      settle();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fl_valid1: got %0b want 1", instr_valid); end
      checks++; if (instr_data !== 32'h00004505) begin errors++; $display("FAIL fl_data: got %h want 00004505", instr_data); end
      checks++; if (instr_pc !== 32'h102) begin errors++; $display("FAIL fl_pc1: got %h want 00000102", instr_pc); end
      instr_ready = 1'b1;
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_drain: got %0b want 0", instr_valid); end
      checks++; if (instr_pc !== 32'h104) begin errors++; $display("FAIL fl_pc2: got %h want 00000104", instr_pc); end
   endtask

   task automatic test_backpressure();
      do_reset();
      instr_ready = 1'b1;
      mem_valid = 1'b1; mem_data = 32'h00934501; mem_addr = 32'h0;
      tick();
      mem_data = 32'h450700A0; mem_addr = 32'h4;
      settle();
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_fill: got %0b want 1", mem_ready); end
      tick();
      instr_ready = 1'b0;
      mem_data = 32'h55555555; mem_addr = 32'h8;
      for (int i = 0; i < 5; i++) begin
         settle();
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, instr_valid); end
         checks++; if (instr_data !== 32'h00A00093) begin errors++; $display("FAIL bp_data[%0d]: got %h want 00a00093", i, instr_data); end
         checks++; if (instr_pc !== 32'h2) begin errors++; $display("FAIL bp_pc[%0d]: got %h want 00000002", i, instr_pc); end
         checks++; if (instr_compressed !== 1'b0) begin errors++; $display("FAIL bp_comp[%0d]: got %0b want 0", i, instr_compressed); end
         checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, mem_ready); end
         tick();
      end
      mem_valid = 1'b0;
      instr_ready = 1'b1;
      settle();
      tick();
      checks++; if (instr_data !== 32'h00004507) begin errors++; $display("FAIL bp_data_after: got %h want 00004507", instr_data); end
      checks++; if (instr_pc !== 32'h6) begin errors++; $display("FAIL bp_pc_after: got %h want 00000006", instr_pc); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", instr_valid); end
   endtask

   task automatic test_flush_straddle();
      do_reset();
      instr_ready = 1'b1;
      mem_valid = 1'b1; mem_data = 32'h00934501; mem_addr = 32'h0;
      tick();
      mem_valid = 1'b0;
      tick();
      flush = 1'b1; flush_pc = 32'h40;
      mem_valid = 1'b1; mem_data = 32'h000000A0; mem_addr = 32'h4;
      settle();
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL fs_ready: got %0b want 0", mem_ready); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fs_valid_during: got %0b want 0", instr_valid); end
      tick();
      flush = 1'b0; mem_valid = 1'b0;
      settle();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fs_valid_after: got %0b want 0", instr_valid); end
      checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL fs_pc: got %h want 00000040", instr_pc); end
      checks++; if (instr_compressed !== 1'b0) begin errors++; $display("FAIL fs_comp: got %0b want 0", instr_compressed); end
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL fs_ready_after: got %0b want 1", mem_ready); end
   endtask

   task automatic test_flush_while_valid();
      do_reset();
      mem_valid = 1'b1; mem_data = 32'h00A00093; mem_addr = 32'h0;
      tick();
      mem_valid = 1'b0;
      instr_ready = 1'b1; flush = 1'b1; flush_pc = 32'h80;
      settle();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fv_valid_before: got %0b want 1", instr_valid); end
      tick();
      flush = 1'b0;
      mem_valid = 1'b1; mem_data = 32'h00100113; mem_addr = 32'h80;
      settle();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fv_valid_after: got %0b want 0", instr_valid); end
      checks++; if (instr_pc !== 32'h80) begin errors++; $display("FAIL fv_pc: got %h want 00000080", instr_pc); end
      tick();
      mem_valid = 1'b0;
      settle();
      checks++; if (instr_data !== 32'h00100113) begin errors++; $display("FAIL fv_data: got %h want 00100113", instr_data); end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_aligned();
      test_compressed_pair();
      test_straddle();
      test_flush_stale();
      test_backpressure();
      test_flush_straddle();
      test_flush_while_valid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_aligner.md
Name: instr_aligner

Overview:
- Fetch-side parcel aligner for RV32IC. Sits between instruction memory and the decompressor/decode stage.
- Accepts word-aligned 32-bit fetch words and splits them into 16-bit parcels. Emits one instruction per handshake: either a 16-bit compressed parcel to be expanded by the decompressor, or a full 32-bit instruction, including ones that straddle a word boundary.
- Handles redirects (flush) to halfword-aligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  fetch word present.
- mem_ready  out  1  aligner accepts mem_data this cycle.
- mem_data  in  32  fetch word, little-endian; the low halfword is the lower address.
- mem_addr  in  32  word-aligned address of mem_data.
- flush  in  1  redirect; has priority over everything else.
- flush_pc  in  32  redirect target; bit0 = 0, bit1 may be 1.
- instr_valid  out  1  instr_data holds a complete instruction.
- instr_ready  in  1  downstream consumes the instruction.
- instr_data  out  32  compressed: {16'h0000, parcel}; otherwise the full 32-bit instruction.
- instr_compressed  out  1  instr_data[1:0] != 2'b11.
- instr_pc  out  32  PC of instr_data.

Behaviour:
- State:
  - buf[47:0]: three halfword slots; slot0 is the head.
  - cnt: 0..3 valid halfwords.
  - head_pc[31:0].
  - drop_low: 1 bit.
  - exp_addr[31:0]: word address expected next from memory.
  - synced: 1 bit.
- Reset: cnt=0, drop_low=0, head_pc=RESET_PC, exp_addr=RESET_PC, synced=0.
  - Outputs after reset: instr_valid=0, instr_data=0, instr_compressed=0, instr_pc=RESET_PC.
- Output decode is combinational from registered state only.
  - compressed = buf[1:0] != 2'b11.
  - instr_valid = (cnt>=1 && compressed) || cnt>=2.
  - instr_data = compressed ? {16'h0, buf[15:0]} : buf[31:0].
  - instr_pc = head_pc.
- Fire: fire_o = instr_valid && instr_ready.
  - Consumes 1 slot if compressed, otherwise 2.
  - head_pc advances by +2 if compressed, otherwise +4.
  - Remaining slots shift down.
- Accept:
  - mem_ready = !flush && (cnt - consumed) <= 1. This is a deliberate combinational path from instr_ready.
  - Accepting a word when (cnt - consumed) == 1 leaves cnt=3, so the slot0 parcel consumed by a compressed fire is the only one that frees room.
  - On acceptance with mem_addr == exp_addr: append both halfwords after the shifted remainder, or only mem_data[31:16] if drop_low=1. Then clear drop_low and advance exp_addr += 4.
  - On acceptance with mem_addr != exp_addr: the word is stale from before a redirect. Drop it; the buffer, exp_addr and drop_low are unchanged.
- Latency: a word accepted in cycle N can produce instr_valid in cycle N+1.
- Throughput:
  - Sustained 1 instruction/cycle for aligned 32-bit streams.
  - 2 compressed instructions per accepted word.
- Straddling instruction: high half of word k plus low half of word k+1. instr_valid stays 0 until the second word is accepted.
- While instr_valid=1 and instr_ready=0, instr_data, instr_pc and instr_compressed hold stable. Appends never touch slot0 when cnt>=1.
- Flush (any cycle, including mid-straddle and with instr_valid=1):
  - Next cycle: cnt=0, head_pc=flush_pc, exp_addr={flush_pc[31:2],2'b00}, drop_low=flush_pc[1].
  - During the flush cycle: mem_ready=0, and no fire effect on state even if instr_ready=1.
  - instr_valid is 0 in the cycle after a flush.
- Reset takes precedence over flush. Reset mid-operation discards all buffered parcels.
- synced is informational only: set on the first matching accept after reset or flush. The aligner does not use it for control.
- No legality checking: 16'h0000 is emitted as a compressed parcel; illegal-instruction detection belongs downstream.
- head_pc wraps modulo 2^32.

Test Plan:
- Reset then words 0x00A00093, 0x00100113 at 0x0,0x4 with instr_ready=1 -> instr 0x00A00093 @0x0, then 0x00100113 @0x4; compressed=0; mem_ready held high; one instruction per cycle.
- Word 0x45054501 at 0x0 -> 0x00004501 @0x0 (compressed=1), then 0x00004505 @0x2; only one word accepted.
- Straddle: 0x00934501 @0x0 then 0x????00A0 @0x4 -> 0x4501 @0x0, then 0x00A00093 @0x2; instr_valid stays low between the two fetches.
- flush_pc=0x102 with words 0xDEADBEEF at 0x200 (stale) then 0x4505CAFE at 0x100 -> stale word dropped, low half 0xCAFE skipped, output 0x00004505 @0x102.
- instr_ready=0 for 5 cycles with instr_valid=1 -> outputs stable, cnt saturates at 3, mem_ready low.
- Flush asserted during a straddle (cnt=1, upper half 0x0093 held) with instr_ready=1 -> no fire; next cycle instr_valid=0, cnt=0, instr_pc=flush_pc.
